// File: rtl/serial_operand_loader.sv
// Deserialises two bit streams into parallel operand pairs with a valid/ready output slot.
// Optional macro OPLOAD_CIN_EN adds a trailing strobe that captures a carry-in from x1.
module serial_operand_loader #(
  parameter int WIDTH     = 16,
  parameter bit LSB_FIRST = 1'b1,
`ifdef OPLOAD_CIN_EN
  localparam int NBITS    = WIDTH + 1,
`else
  localparam int NBITS    = WIDTH,
`endif
  localparam int CNT_W    = $clog2(NBITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x1,
  input  logic             x2,
  input  logic             bit_stb,
  output logic             in_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             cin,
  output logic             op_valid,
  input  logic             op_ready,
  output logic             overrun,
  output logic [CNT_W-1:0] bit_cnt
);

  typedef enum logic {FILL, FULL} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sha_q, sha_d, shb_q, shb_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               vld_q, vld_d, ovr_q, ovr_d;
  logic [WIDTH-1:0]   sha_nx, shb_nx;
`ifdef OPLOAD_CIN_EN
  logic               cin_q, cin_d, cinsh_q, cinsh_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      sha_q   <= '0;
      shb_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      vld_q   <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef OPLOAD_CIN_EN
      cin_q   <= 1'b0;
      cinsh_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sha_q   <= sha_d;
      shb_q   <= shb_d;
      a_q     <= a_d;
      b_q     <= b_d;
      vld_q   <= vld_d;
      ovr_q   <= ovr_d;
`ifdef OPLOAD_CIN_EN
      cin_q   <= cin_d;
      cinsh_q <= cinsh_d;
`endif
    end
  end

  always_comb begin
    if (LSB_FIRST) begin
      sha_nx = {x1, sha_q[WIDTH-1:1]};
      shb_nx = {x2, shb_q[WIDTH-1:1]};
    end else begin
      sha_nx = {sha_q[WIDTH-2:0], x1};
      shb_nx = {shb_q[WIDTH-2:0], x2};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sha_d   = sha_q;
    shb_d   = shb_q;
    a_d     = a_q;
    b_d     = b_q;
    vld_d   = vld_q;
    ovr_d   = ovr_q;
`ifdef OPLOAD_CIN_EN
    cin_d   = cin_q;
    cinsh_d = cinsh_q;
`endif
    // A consumed pair empties the slot unless a replacement loads below.
    if (vld_q && op_ready) vld_d = 1'b0;
    unique case (state_q)
      FILL: begin
        if (bit_stb) begin
`ifdef OPLOAD_CIN_EN
          if (cnt_q == CNT_W'(WIDTH)) begin
            cinsh_d = x1;
          end else begin
            sha_d = sha_nx;
            shb_d = shb_nx;
          end
`else
          sha_d = sha_nx;
          shb_d = shb_nx;
`endif
          if (cnt_q == CNT_W'(NBITS - 1)) begin
            if (!vld_q || op_ready) begin
              a_d   = sha_d;
              b_d   = shb_d;
`ifdef OPLOAD_CIN_EN
              cin_d = cinsh_d;
`endif
              vld_d = 1'b1;
              cnt_d = '0;
            end else begin
              cnt_d   = CNT_W'(NBITS);
              state_d = FULL;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      FULL: begin
        if (bit_stb) ovr_d = 1'b1;
        if (op_ready) begin
          a_d     = sha_q;
          b_d     = shb_q;
`ifdef OPLOAD_CIN_EN
          cin_d   = cinsh_q;
`endif
          vld_d   = 1'b1;
          cnt_d   = '0;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  assign in_ready = (state_q == FILL);
  assign a        = a_q;
  assign b        = b_q;
  assign op_valid = vld_q;
  assign overrun  = ovr_q;
  assign bit_cnt  = cnt_q;
`ifdef OPLOAD_CIN_EN
  assign cin      = cin_q;
`else
  assign cin      = 1'b0;
`endif

endmodule
